pulp_clkgate_ctrl: RTL and testbench
====================================

# pulp_clkgate_ctrl

Automatic clock-gate enable controller, directly upstream of the `pulp_clock_gating` ICG cell. It runs on the free-running clock, watches a gated domain for idleness, and negotiates a stop handshake with that domain before deasserting the ICG enable. It restores the clock on a wake event and reports readiness after a fixed settle delay. `clk_en_o` connects to the ICG `en_i`; the ICG `test_en_i` is driven by the parent, not by this block.

## Interface
- `CNT_W`, default 8: width of the idle threshold and idle counter.
- `WAKE_CYCLES`, default 2: cycles from clock re-enable to `ready_o`. Legal range 1..15.
- `STAT_W`, default 16: width of the gate-event statistic counter.

Ports:
- `clk_i`  in  1  free-running (ungated) clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `idle_thresh_i`  in  CNT_W  consecutive idle cycles required before a stop request; 0 disables auto-gating.
- `busy_i`  in  1  gated domain has activity in flight.
- `wake_i`  in  1  external request for the domain clock.
- `force_on_i`  in  1  software override; holds the clock on.
- `stop_ack_i`  in  1  gated domain confirms it is quiesced.
- `stat_clr_i`  in  1  clears `gate_count_o`.
- `clk_en_o`  out  1  registered ICG enable.
- `stop_req_o`  out  1  stop request to the gated domain.
- `gated_o`  out  1  clock currently gated.
- `ready_o`  out  1  domain clock is running and settled.
- `gate_count_o`  out  STAT_W  saturating count of entries into GATED.

## Operation
- **State machine states:** RUN, STOP_REQ, GATED, WAKE.
- **Activity:** `act = busy_i | wake_i | force_on_i`.
- **RUN**
  - Outputs: `clk_en_o=1`, `ready_o=1`, `stop_req_o=0`, `gated_o=0`.
  - `idle_cnt` clears when `act=1` or `idle_thresh_i=0`; otherwise it increments.
  - When `act=0`, `idle_thresh_i≠0` and `idle_cnt == idle_thresh_i-1`, go to STOP_REQ and clear `idle_cnt`.
  - `idle_cnt` never wraps. If the threshold drops below the current count, the next idle cycle also triggers STOP_REQ (compare `idle_cnt >= idle_thresh_i-1`).
- **STOP_REQ**
  - Outputs: `stop_req_o=1`, `clk_en_o=1`, `ready_o=1`.
  - If `act=1`: abort to RUN. Abort wins over a simultaneous `stop_ack_i`.
  - Else if `stop_ack_i=1`: go to GATED and increment `gate_count_o`, saturating at all-ones.
  - With no `act` and no ack, wait indefinitely.
- **GATED**
  - Outputs: `clk_en_o=0`, `gated_o=1`, `ready_o=0`, `stop_req_o=1`.
  - `act=1` → WAKE. `stop_ack_i` is ignored here.
- **WAKE**
  - Outputs: `clk_en_o=1`, `gated_o=0`, `stop_req_o=0`, `ready_o=0`.
  - `wcnt` counts from 0; after `WAKE_CYCLES` cycles in WAKE, go to RUN.
  - `act` is ignored here; WAKE is never cut short.
- **Statistic counter:** `stat_clr_i` clears `gate_count_o`. If it coincides with a GATED entry, the result is 1.
- **Output registers:** all outputs are registered and decoded from state. `clk_en_o` must never glitch; the ICG latch relies on this.

## Timing
- **Reset values:** state RUN, `clk_en_o=1`, `ready_o=1`, `stop_req_o=0`, `gated_o=0`, `gate_count_o=0`, all internal counters 0.
- **Reset mid-operation:** reset in any state returns to RUN on the next edge. From GATED, the clock is re-enabled without passing through WAKE.
- **Idle to request:** first idle cycle at edge k gives `stop_req_o=1` in cycle k+N, where N = `idle_thresh_i`.
- **Ack to gate:** `stop_ack_i` sampled at edge t gives `clk_en_o=0` and `gated_o=1` in cycle t+1.
- **Wake:** `act` sampled at edge t gives `clk_en_o=1` in cycle t+1 and `ready_o=1` in cycle t+1+`WAKE_CYCLES`.
- **Abort:** `act` during STOP_REQ gives `stop_req_o=0` the next cycle, and the idle count restarts from 0.

## Structure
- Shared package `pulp_clkgate_pkg`: holds the state enum `clkgate_state_e` and the `WAKE_CYCLES` bound constant.
- Single flat module, no sub-module. The ICG (`pulp_clock_gating`) is instantiated beside this block in the parent.

## Test plan
- **Idle entry:** `idle_thresh_i=4`, `busy_i` falls at cycle 10, ack returned 3 cycles after the request → `stop_req_o` rises at cycle 14; `clk_en_o=0` and `gate_count_o=1` in the cycle after the ack.
- **Abort race:** `stop_ack_i` and `busy_i` asserted in the same STOP_REQ cycle → return to RUN, `clk_en_o` stays 1, `gate_count_o` unchanged.
- **Wake latency:** GATED, pulse `wake_i` at edge t with `WAKE_CYCLES=2` → `clk_en_o=1` at t+1, `ready_o=1` at t+3, `stop_req_o=0` at t+1.
- **Disable and override:** `idle_thresh_i=0` or `force_on_i=1` held for 1000 idle cycles → `stop_req_o` never asserts.
- **Saturation and clear:** `STAT_W=2`, five gate/wake cycles → `gate_count_o=3`; `stat_clr_i` coincident with a GATED entry → `gate_count_o=1`.
- **Reset while gated:** `rst_i` pulsed in GATED → next cycle `clk_en_o=1`, `ready_o=1`, `gated_o=0`.

Source files
------------

// File: rtl/pulp_clkgate_pkg.sv
// Shared types and constants for the automatic clock-gate enable controller.
package pulp_clkgate_pkg;

  // Encoding of the gate controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOP_REQ = 2'd1,
    ST_GATED    = 2'd2,
    ST_WAKE     = 2'd3
  } clkgate_state_e;

  // Upper bound of the wake settle delay; the wake counter is sized for it
  localparam int unsigned WAKE_CYCLES_MAX = 15;
  localparam int unsigned WCNT_W          = 4;

  // Output bundle decoded from state
  typedef struct packed {
    logic clk_en;
    logic stop_req;
    logic gated;
    logic ready;
  } clkgate_out_t;

  // Moore decode of the outputs for a given state
  function automatic clkgate_out_t decode_outputs(clkgate_state_e st);
    clkgate_out_t o;
    o = '{clk_en: 1'b1, stop_req: 1'b0, gated: 1'b0, ready: 1'b1};
    case (st)
      ST_RUN:      o = '{clk_en: 1'b1, stop_req: 1'b0, gated: 1'b0, ready: 1'b1};
      ST_STOP_REQ: o = '{clk_en: 1'b1, stop_req: 1'b1, gated: 1'b0, ready: 1'b1};
      ST_GATED:    o = '{clk_en: 1'b0, stop_req: 1'b1, gated: 1'b1, ready: 1'b0};
      ST_WAKE:     o = '{clk_en: 1'b1, stop_req: 1'b0, gated: 1'b0, ready: 1'b0};
      default:     o = '{clk_en: 1'b1, stop_req: 1'b0, gated: 1'b0, ready: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pulp_clkgate_ctrl.sv
// Automatic clock-gate enable controller driving the enable of the
// pulp_clock_gating ICG. Runs on the free-running clock.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | clock on, counting consecutive idle cycles
// STOP_REQ | clock on, asking the gated domain to quiesce
// GATED    | clock off, waiting for activity
// WAKE     | clock back on, waiting WAKE_CYCLES for it to settle
module pulp_clkgate_ctrl
  import pulp_clkgate_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  idle_thresh_i,
  input  logic              busy_i,
  input  logic              wake_i,
  input  logic              force_on_i,
  input  logic              stop_ack_i,
  input  logic              stat_clr_i,
  output logic              clk_en_o,
  output logic              stop_req_o,
  output logic              gated_o,
  output logic              ready_o,
  output logic [STAT_W-1:0] gate_count_o
);

  // Last wake-counter value before returning to RUN
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);

  clkgate_state_e    state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [STAT_W-1:0] gate_count_q, gate_count_d;
  clkgate_out_t      out_q, out_d;

  logic              act;
  logic              thresh_zero;
  logic [CNT_W-1:0]  thresh_m1;
  logic              idle_hit;
  logic              gate_entry;

  assign act         = busy_i | wake_i | force_on_i;
  assign thresh_zero = (idle_thresh_i == '0);
  assign thresh_m1   = idle_thresh_i - CNT_W'(1);
  // >= rather than == so a threshold lowered below the running count
  // still fires on the next idle cycle instead of wrapping the counter
  assign idle_hit    = !thresh_zero && (idle_cnt_q >= thresh_m1);

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wcnt_d     = wcnt_q;
    gate_entry = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (act || thresh_zero) begin
          idle_cnt_d = '0;
        end else if (idle_hit) begin
          state_d    = ST_STOP_REQ;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP_REQ: begin
        idle_cnt_d = '0;
        // activity beats a simultaneous ack: never gate a busy domain
        if (act) begin
          state_d = ST_RUN;
        end else if (stop_ack_i) begin
          state_d    = ST_GATED;
          gate_entry = 1'b1;
        end
      end

      ST_GATED: begin
        idle_cnt_d = '0;
        if (act) begin
          state_d = ST_WAKE;
          wcnt_d  = '0;
        end
      end

      ST_WAKE: begin
        idle_cnt_d = '0;
        if (wcnt_q == WAKE_LAST) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wcnt_d     = '0;
      end
    endcase

    if (stat_clr_i) begin
      gate_count_d = gate_entry ? STAT_W'(1) : '0;
    end else if (gate_entry && (gate_count_q != '1)) begin
      gate_count_d = gate_count_q + STAT_W'(1);
    end else begin
      gate_count_d = gate_count_q;
    end

    // outputs registered from the next state so they change cleanly on the edge
    out_d = decode_outputs(state_d);
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      idle_cnt_q   <= '0;
      wcnt_q       <= '0;
      gate_count_q <= '0;
      out_q        <= decode_outputs(ST_RUN);
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wcnt_q       <= wcnt_d;
      gate_count_q <= gate_count_d;
      out_q        <= out_d;
    end
  end

  assign clk_en_o     = out_q.clk_en;
  assign stop_req_o   = out_q.stop_req;
  assign gated_o      = out_q.gated;
  assign ready_o      = out_q.ready;
  assign gate_count_o = gate_count_q;

endmodule

// File: tb/tb_pulp_clkgate_ctrl.sv
// Vector bench for pulp_clkgate_ctrl with a small statistic counter so
// saturation is reachable.
module tb_pulp_clkgate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] idle_thresh_i;
  logic       busy_i, wake_i, force_on_i, stop_ack_i, stat_clr_i;
  logic       clk_en_o, stop_req_o, gated_o, ready_o;
  logic [1:0] gate_count_o;

  always #5 clk_i = ~clk_i;

  pulp_clkgate_ctrl #(
    .CNT_W      (8),
    .WAKE_CYCLES(2),
    .STAT_W     (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idle_thresh_i(idle_thresh_i),
    .busy_i       (busy_i),
    .wake_i       (wake_i),
    .force_on_i   (force_on_i),
    .stop_ack_i   (stop_ack_i),
    .stat_clr_i   (stat_clr_i),
    .clk_en_o     (clk_en_o),
    .stop_req_o   (stop_req_o),
    .gated_o      (gated_o),
    .ready_o      (ready_o),
    .gate_count_o (gate_count_o)
  );

  // {clk_en, stop_req, gated, ready}
  localparam logic [3:0] RUNO = 4'b1001;
  localparam logic [3:0] SRQ  = 4'b1101;
  localparam logic [3:0] GAT  = 4'b0110;
  localparam logic [3:0] WAK  = 4'b1000;

  typedef struct {
    logic       rst, busy, wake, force_on, ack, clr;
    logic [7:0] thresh;
    logic [3:0] exp_o;
    logic [1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic busy, logic wake, logic force_on,
                              logic ack, logic clr, logic [7:0] thresh,
                              logic [3:0] exp_o, logic [1:0] exp_cnt);
    vec_t v;
    v.rst = rst; v.busy = busy; v.wake = wake; v.force_on = force_on;
    v.ack = ack; v.clr = clr; v.thresh = thresh;
    v.exp_o = exp_o; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check();
    exp_t       e;
    logic [5:0] got;
    e   = sb.pop_front();
    got = {clk_en_o, stop_req_o, gated_o, ready_o, gate_count_o};
    n_vec++;
    if (got !== e.val) begin
      n_err++;
      $display("FAIL %s: got en/req/gated/rdy/cnt=%b want %b", e.name, got, e.val);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    rst_i         = v.rst;
    busy_i        = v.busy;
    wake_i        = v.wake;
    force_on_i    = v.force_on;
    stop_ack_i    = v.ack;
    stat_clr_i    = v.clr;
    idle_thresh_i = v.thresh;
    e.val  = {v.exp_o, v.exp_cnt};
    e.name = nm;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check();
  endtask

  // From RUN with threshold 1: request, ack, wake, settle back to RUN
  task automatic gate_cycle(input logic [1:0] cnt_after, input string nm);
    apply(mk(0,0,0,0,0,0,8'd1,SRQ ,cnt_after == 2'd0 ? 2'd0 : cnt_after - 2'd1 + ((cnt_after == 2'd3) ? 2'd0 : 2'd0)), {nm, "_req"});
    apply(mk(0,0,0,0,1,0,8'd1,GAT ,cnt_after), {nm, "_gate"});
    apply(mk(0,0,1,0,0,0,8'd1,WAK ,cnt_after), {nm, "_wake0"});
    apply(mk(0,0,0,0,0,0,8'd1,WAK ,cnt_after), {nm, "_wake1"});
    apply(mk(0,0,0,0,0,0,8'd1,RUNO,cnt_after), {nm, "_run"});
  endtask

  vec_t tbl[38];

  initial begin
    rst_i = 1'b1; busy_i = 1'b1; wake_i = 1'b0; force_on_i = 1'b0;
    stop_ack_i = 1'b0; stat_clr_i = 1'b0; idle_thresh_i = 8'd4;

    //           rst busy wake frc ack clr thresh exp   cnt
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);  // reset state
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);  // idle 1
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 8'd4, SRQ , 2'd0);  // 4th idle -> request
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 8'd4, SRQ , 2'd0);  // waits for ack
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 8'd4, GAT , 2'd1);  // ack -> gated
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 8'd4, GAT , 2'd1);  // ack ignored
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 8'd4, WAK , 2'd1);  // wake edge t
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 8'd4, WAK , 2'd1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);  // ready at t+3
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 8'd4, SRQ , 2'd1);
    tbl[16] = mk(0, 1, 0, 0, 1, 0, 8'd4, RUNO, 2'd1);  // abort beats ack
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);  // idle restarts at 0
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 8'd4, SRQ , 2'd1);
    tbl[21] = mk(0, 0, 0, 0, 1, 0, 8'd4, GAT , 2'd2);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 8'd4, RUNO, 2'd0);  // reset while gated
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 8'd1, SRQ , 2'd0);  // threshold 1
    tbl[24] = mk(0, 0, 0, 0, 1, 0, 8'd1, GAT , 2'd1);
    tbl[25] = mk(0, 0, 0, 1, 0, 0, 8'd1, WAK , 2'd1);  // force_on wakes
    tbl[26] = mk(0, 0, 0, 1, 0, 0, 8'd1, WAK , 2'd1);
    tbl[27] = mk(0, 0, 0, 1, 0, 0, 8'd1, RUNO, 2'd1);
    tbl[28] = mk(0, 0, 0, 1, 0, 0, 8'd1, RUNO, 2'd1);  // override holds RUN
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 8'd1, SRQ , 2'd1);
    tbl[30] = mk(0, 0, 0, 0, 1, 0, 8'd1, GAT , 2'd2);
    tbl[31] = mk(0, 0, 1, 0, 0, 0, 8'd1, WAK , 2'd2);
    tbl[32] = mk(0, 0, 0, 0, 0, 0, 8'd1, WAK , 2'd2);
    tbl[33] = mk(0, 0, 0, 0, 0, 0, 8'd1, RUNO, 2'd2);
    tbl[34] = mk(0, 0, 0, 0, 0, 1, 8'd0, RUNO, 2'd0);  // clear, disabled
    tbl[35] = mk(0, 0, 0, 0, 0, 0, 8'd3, RUNO, 2'd0);  // count -> 1
    tbl[36] = mk(0, 0, 0, 0, 0, 0, 8'd3, RUNO, 2'd0);  // count -> 2
    tbl[37] = mk(0, 0, 0, 0, 0, 0, 8'd2, SRQ , 2'd0);  // threshold dropped

    for (int i = 0; i < 38; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // saturation: first entry from the pending request, then four full cycles
    apply(mk(0,0,0,0,1,0,8'd1,GAT ,2'd1), "sat1_gate");
    apply(mk(0,0,1,0,0,0,8'd1,WAK ,2'd1), "sat1_wake0");
    apply(mk(0,0,0,0,0,0,8'd1,WAK ,2'd1), "sat1_wake1");
    apply(mk(0,0,0,0,0,0,8'd1,RUNO,2'd1), "sat1_run");
    begin
      logic [1:0] prev;
      logic [1:0] nxt;
      prev = 2'd1;
      for (int n = 2; n <= 5; n++) begin
        nxt = (n >= 3) ? 2'd3 : 2'(n);
        apply(mk(0,0,0,0,0,0,8'd1,SRQ ,prev), $sformatf("sat%0d_req", n));
        apply(mk(0,0,0,0,1,0,8'd1,GAT ,nxt ), $sformatf("sat%0d_gate", n));
        apply(mk(0,0,1,0,0,0,8'd1,WAK ,nxt ), $sformatf("sat%0d_wake0", n));
        apply(mk(0,0,0,0,0,0,8'd1,WAK ,nxt ), $sformatf("sat%0d_wake1", n));
        apply(mk(0,0,0,0,0,0,8'd1,RUNO,nxt ), $sformatf("sat%0d_run", n));
        prev = nxt;
      end
    end

    // clear coincident with a gate entry leaves exactly one
    apply(mk(0,0,0,0,0,0,8'd1,SRQ ,2'd3), "clr_req");
    apply(mk(0,0,0,0,1,1,8'd1,GAT ,2'd1), "clr_on_entry");
    apply(mk(0,0,1,0,0,0,8'd1,WAK ,2'd1), "clr_wake0");
    apply(mk(0,0,0,0,0,0,8'd1,WAK ,2'd1), "clr_wake1");
    apply(mk(0,0,0,0,0,0,8'd1,RUNO,2'd1), "clr_run");

    // disabled threshold and software override over long idle stretches
    for (int i = 0; i < 1000; i++)
      apply(mk(0,0,0,0,0,0,8'd0,RUNO,2'd1), "thresh_zero");
    for (int i = 0; i < 1000; i++)
      apply(mk(0,0,0,1,0,0,8'd1,RUNO,2'd1), "force_on");

    // reset while gated restores the clock directly
    apply(mk(0,0,0,0,0,0,8'd1,SRQ ,2'd1), "rg_req");
    apply(mk(0,0,0,0,1,0,8'd1,GAT ,2'd2), "rg_gate");
    apply(mk(0,0,0,0,0,0,8'd1,GAT ,2'd2), "rg_hold");
    apply(mk(1,0,0,0,0,0,8'd1,RUNO,2'd0), "rg_reset");
    apply(mk(0,1,0,0,0,0,8'd1,RUNO,2'd0), "rg_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
